ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Microcode sequencer between the command ROM and the pairing datapath. On `start` it reads a program from the ROM, beginning at a header word at `entry`. It issues each following command word to the datapath the number of times given by the count field of the word before it. It stops after the last repetition of the word flagged final. The ROM is registered with one-cycle read latency; the sequencer drives its address so that commands issue back-to-back with no bubbles.

## Interface
- `ADDR_W`, 10, ROM address width; `rom_addr` and `entry` use it; `pc` wraps modulo 2^ADDR_W.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin program at `entry`; sampled only in IDLE.
- `entry` in ADDR_W: address of header word; sampled with `start`.
- `hold` in 1: datapath back-pressure; freezes RUN progress.
- `rom_addr` out ADDR_W: ROM address, driven combinationally from next-state `pc`.
- `rom_q` in 32: ROM data; valid the cycle after its address is presented.
- `cmd_valid` out 1: command on `cmd`/`ram_a`/`ram_b` is issued this cycle.
- `cmd` out 11: datapath control field.
- `ram_a` out 7: first operand/load address.
- `ram_b` out 7: second operand address.
- `busy` out 1: high in LOAD, FILL, RUN.
- `done` out 1: one-cycle pulse after the final issue.

## Operation
- Word fields: [31:26] `cnt`; [25] `fin`; [24:18] `ram_a`; [17:11] `ram_b`; [10:0] `cmd`.
- `cnt` of word N is the repeat count of word N+1. `cnt`=0 is treated as 1.
- The header word is never issued; only its `cnt` is used.
- `rom_addr` = `pc_next`, so `rom_q` always equals word[`pc`].
- Registers: `pc`, instruction register `ir` (32 bits), `rem` (6 bits), state.
- IDLE: `start` → `pc`←`entry`, go to LOAD. `start` in any other state is ignored.
- LOAD: `rom_q` is the header. `rem`←max(`cnt`,1), `pc`←`pc`+1, go to FILL.
- FILL: `ir`←`rom_q`, `pc`←`pc`+1, go to RUN.
- RUN, `cmd_valid`=!`hold`: outputs are the `ir` fields.
  - `hold`: nothing changes.
  - Else if `rem`>1: `rem`←`rem`−1.
  - Else if `ir.fin`: go to IDLE, `done`←1.
  - Else: `ir`←`rom_q`, `rem`←max(`ir.cnt`,1), `pc`←`pc`+1.
- `pc` wraps from 2^ADDR_W−1 to 0 silently.
- Outputs `cmd`/`ram_a`/`ram_b` hold the last `ir` value outside RUN.

## Timing
- Reset: state IDLE; `pc`, `ir`, `rem` = 0; `rom_addr`=0; `cmd_valid`, `busy`, `done` = 0; `cmd`/`ram_a`/`ram_b` = 0.
- Reset asserted mid-program aborts it with the state above. There is no `done` pulse.
- Latency: with `start` high in cycle 0, LOAD is cycle 1, FILL is cycle 2, and the first `cmd_valid` is in cycle 3.
- Throughput: one issue per non-held RUN cycle, including across word boundaries.
- `done` goes high in the cycle after the final issue, together with `busy`=0.
- `start` is accepted in the same cycle `done` is high, because the state is IDLE.
- `hold` during the final issue keeps the command valid-pending; `done` follows the first non-held issue.
- `hold` is ignored outside RUN.

## Structure
- Shared package `ctrl_pkg`:
  - field bit-position localparams (`CNT_HI`/`LO`, `FIN_BIT`, `RA_HI`/`LO`, `RB_HI`/`LO`, `CMD_HI`/`LO`);
  - state enum {IDLE, LOAD, FILL, RUN};
  - a `cmd_word_t` struct matching the word layout.
- ROM writers use the same package.
- Single module, no sub-module; next-state/`pc_next` logic is one combinational block.

## Test plan
- Program at 0:
  - words: {1,0,0,0,0}, {1,0,0,2,0}, {2,0,4,2,11'b11000000000}, {1,1,3,0,11'b00111010001};
  - `start` cycle 0 → `cmd_valid` cycles 3–6 with (`ram_a`,`ram_b`) = (0,2), (4,2), (3,0), (3,0);
  - `done` in cycle 7; `busy` in cycles 1–6.
- Same program, `hold` high in cycles 4–5 → word 2 is presented in cycles 4–6 and is valid only in cycle 6; word 3 issues in cycles 7–8; `done` in cycle 9.
- Header `cnt`=0 and an intermediate `cnt`=0 → each affected word issues exactly once.
- `entry`=1022 with a 4-word program → `rom_addr` sequence 1022, 1023, 0, 1; all three commands issue; `done` asserts.
- `reset` in cycle 4 of the first scenario → next cycle all outputs 0, state IDLE; a `start` in cycle 6 re-runs the program correctly.
- `start` pulsed during RUN → ignored; `start` in the `done` cycle → next program's first `cmd_valid` 3 cycles later.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: command word layout, sequencer states and repeat-count helper
// shared by the sequencer and by anything that writes the command ROM.
package ctrl_pkg;
   localparam int CNT_HI = 31;
   localparam int CNT_LO = 26;
   localparam int FIN_BIT = 25;
   localparam int RA_HI = 24;
   localparam int RA_LO = 18;
   localparam int RB_HI = 17;
   localparam int RB_LO = 11;
   localparam int CMD_HI = 10;
   localparam int CMD_LO = 0;
   typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;
   typedef struct packed {
      logic [CNT_HI-CNT_LO:0] cnt;
      logic fin;
      logic [RA_HI-RA_LO:0] ram_a;
      logic [RB_HI-RB_LO:0] ram_b;
      logic [CMD_HI-CMD_LO:0] cmd;
   } cmd_word_t;
   // A zero count still issues the following word once.
   function automatic logic [5:0] rep(input logic [5:0] cnt);
      return cnt == 6'd0 ? 6'd1 : cnt;
   endfunction
endpackage

// File: rtl/ctrl_seq.sv
// ctrl_seq: microcode sequencer; fetches a header plus command words from a
// one-cycle-latency ROM and issues each command back-to-back with repeats.
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] entry,
   input  logic              hold,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_q,
   output logic              cmd_valid,
   output logic [10:0]       cmd,
   output logic [6:0]        ram_a,
   output logic [6:0]        ram_b,
   output logic              busy,
   output logic              done
);
   state_t state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   cmd_word_t ir, ir_n, q;
   logic [5:0] rem, rem_n;
   logic done_n;
   assign q = cmd_word_t'(rom_q);
   // The ROM is addressed with next pc so rom_q always holds word[pc].
   always_comb begin
      state_n = state;
      pc_n = pc;
      ir_n = ir;
      rem_n = rem;
      done_n = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_n = LOAD;
            pc_n = entry;
         end
         LOAD: begin
            rem_n = rep(q.cnt);
            pc_n = pc + 1'b1;
            state_n = FILL;
         end
         FILL: begin
            ir_n = q;
            pc_n = pc + 1'b1;
            state_n = RUN;
         end
         RUN: if (!hold) begin
            if (rem > 6'd1) rem_n = rem - 6'd1;
            else if (ir.fin) begin
               state_n = IDLE;
               done_n = 1'b1;
            end else begin
               ir_n = q;
               rem_n = rep(ir.cnt);
               pc_n = pc + 1'b1;
            end
         end
      endcase
      if (reset) pc_n = '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc <= '0;
         ir <= '0;
         rem <= '0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         ir <= ir_n;
         rem <= rem_n;
         done <= done_n;
      end
   end
   assign rom_addr = pc_n;
   assign cmd_valid = state == RUN && !hold;
   assign busy = state != IDLE;
   assign cmd = ir.cmd;
   assign ram_a = ir.ram_a;
   assign ram_b = ir.ram_b;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scenarios against a registered ROM model, comparing
// per-cycle {done,busy,cmd_valid,ram_a,ram_b} with hand-computed tables.
module tb_ctrl_seq;
   import ctrl_pkg::*;
   logic clk = 1'b0, reset, start, hold, cmd_valid, busy, done;
   logic [9:0] entry, rom_addr;
   logic [31:0] rom_q;
   logic [10:0] cmd;
   logic [6:0] ram_a, ram_b;
   logic [31:0] rom [1024];
   logic [16:0] obs [32];
   logic [9:0] adr [32];
   logic [10:0] cmdo [32];
   logic [16:0] exp_q [$];
   int n_cmp = 0, n_bad = 0;

   ctrl_seq #(.ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .start(start), .entry(entry), .hold(hold),
      .rom_addr(rom_addr), .rom_q(rom_q), .cmd_valid(cmd_valid), .cmd(cmd),
      .ram_a(ram_a), .ram_b(ram_b), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_q <= rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] w(input int cnt, fin, ra, rb, c);
      cmd_word_t x;
      x.cnt = 6'(cnt);
      x.fin = 1'(fin);
      x.ram_a = 7'(ra);
      x.ram_b = 7'(rb);
      x.cmd = 11'(c);
      return x;
   endfunction

   function automatic logic [16:0] pk(input int d, b, v, ra, rb);
      return {1'(d), 1'(b), 1'(v), 7'(ra), 7'(rb)};
   endfunction

   task automatic load_prog0();
      rom[0] = w(1, 0, 0, 0, 0);
      rom[1] = w(1, 0, 0, 2, 0);
      rom[2] = w(2, 0, 4, 2, 11'b11000000000);
      rom[3] = w(1, 1, 3, 0, 11'b00111010001);
   endtask

   // Entered and left at posedge+1; bit c of each mask drives cycle c.
   task automatic run(input int n, input logic [31:0] sm, hm, rm, input logic [9:0] ent);
      for (int c = 0; c < n; c++) begin
         start = sm[c];
         hold = hm[c];
         reset = rm[c];
         entry = ent;
         #2;
         obs[c] = {done, busy, cmd_valid, ram_a, ram_b};
         adr[c] = rom_addr;
         cmdo[c] = cmd;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      hold = 1'b0;
      reset = 1'b0;
   endtask

   task automatic cmp_run(input string tag, input int from);
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s c%0d", tag, from + i), 32'(obs[from + i]), 32'(exp_q[i]));
   endtask

   initial begin
      foreach (rom[i]) rom[i] = '0;
      reset = 1'b1;
      start = 1'b0;
      hold = 1'b0;
      entry = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #2;
      check("rst outs", {done, busy, cmd_valid, ram_a, ram_b, cmd}, 0);
      check("rst rom_addr", 32'(rom_addr), 0);
      @(posedge clk);
      #1;
      load_prog0();
      run(9, 32'h1, 32'h0, 32'h0, 10'd0);
      exp_q = '{pk(0,0,0,0,0), pk(0,1,0,0,0), pk(0,1,0,0,0), pk(0,1,1,0,2), pk(0,1,1,4,2),
                pk(0,1,1,3,0), pk(0,1,1,3,0), pk(1,0,0,3,0), pk(0,0,0,3,0)};
      cmp_run("basic", 0);
      check("basic cmd c4", 32'(cmdo[4]), 32'(11'b11000000000));
      check("basic cmd c5", 32'(cmdo[5]), 32'(11'b00111010001));
      run(11, 32'h1, 32'h36, 32'h0, 10'd0);
      exp_q = '{pk(0,1,1,0,2), pk(0,1,0,4,2), pk(0,1,0,4,2), pk(0,1,1,4,2), pk(0,1,1,3,0),
                pk(0,1,1,3,0), pk(1,0,0,3,0), pk(0,0,0,3,0)};
      cmp_run("hold", 3);
      rom[16] = w(0, 0, 0, 0, 0);
      rom[17] = w(0, 0, 1, 1, 5);
      rom[18] = w(0, 1, 2, 2, 6);
      run(7, 32'h1, 32'h0, 32'h0, 10'd16);
      exp_q = '{pk(0,1,1,1,1), pk(0,1,1,2,2), pk(1,0,0,2,2), pk(0,0,0,2,2)};
      cmp_run("cnt0", 3);
      rom[1022] = w(1, 0, 0, 0, 0);
      rom[1023] = w(1, 0, 5, 6, 7);
      rom[0] = w(1, 0, 7, 8, 9);
      rom[1] = w(1, 1, 9, 10, 11);
      run(8, 32'h1, 32'h0, 32'h0, 10'd1022);
      check("wrap addr c0", 32'(adr[0]), 1022);
      check("wrap addr c1", 32'(adr[1]), 1023);
      check("wrap addr c2", 32'(adr[2]), 0);
      check("wrap addr c3", 32'(adr[3]), 1);
      exp_q = '{pk(0,1,1,5,6), pk(0,1,1,7,8), pk(0,1,1,9,10), pk(1,0,0,9,10)};
      cmp_run("wrap", 3);
      load_prog0();
      run(15, 32'h41, 32'h0, 32'h10, 10'd0);
      check("abort addr c5", 32'(adr[5]), 0);
      exp_q = '{pk(0,0,0,0,0), pk(0,0,0,0,0), pk(0,1,0,0,0), pk(0,1,0,0,0), pk(0,1,1,0,2),
                pk(0,1,1,4,2), pk(0,1,1,3,0), pk(0,1,1,3,0), pk(1,0,0,3,0), pk(0,0,0,3,0)};
      cmp_run("abort", 5);
      run(16, 32'h91, 32'h0, 32'h0, 10'd0);
      exp_q = '{pk(0,1,1,0,2), pk(0,1,1,4,2), pk(0,1,1,3,0), pk(0,1,1,3,0), pk(1,0,0,3,0),
                pk(0,1,0,3,0), pk(0,1,0,3,0), pk(0,1,1,0,2), pk(0,1,1,4,2), pk(0,1,1,3,0),
                pk(0,1,1,3,0), pk(1,0,0,3,0), pk(0,0,0,3,0)};
      cmp_run("restart", 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
